module_uart_tx: RTL and testbench

//  UART transmit serializer: consumes the 8-bit byte held by the UART data register
//  and shifts it out on the tx line as an 8N1 frame (start, D0..D7 LSB first, stop).

---
 rtl/module_uart_tx_pkg.sv | 15 +
 rtl/module_uart_tx_baud_tick.sv | 31 +++
 rtl/module_uart_tx.sv | 126 ++++++++++++
 tb/tb_module_uart_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/module_uart_tx_pkg.sv
// Shared types and widths for the UART transmit path.
package pkg_uart;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int UART_DATA_W   = 8;
    localparam int UART_BITIDX_W = 3;

endpackage

// File: rtl/module_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle (tick_o) and the one before it (pre_tick_o) so callers can register end-of-bit events.
module module_baud_tick #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_o     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_tick_o = (cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= tick_o ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/module_uart_tx.sv
// UART 8N1 transmit serializer; define UART_TX_PARITY_EN to insert a parity bit
// (even/odd chosen by PARITY_ODD) between D7 and the stop bit.
module module_uart_tx
    import pkg_uart::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   send_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    tx_state_t                state, state_nxt;
    logic [UART_DATA_W-1:0]   sr, sr_nxt;
    logic [UART_BITIDX_W-1:0] idx, idx_nxt;
    logic                     par, par_nxt;
    logic                     tx_nxt, busy_nxt, done_nxt;
    logic                     clr, tick, pre_tick;

    module_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr),
        .en_i      (state != TX_IDLE),
        .tick_o    (tick),
        .pre_tick_o(pre_tick)
    );

    // Outputs are computed one cycle ahead so tx_o/busy_o/done_o come straight from flops.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        idx_nxt   = idx;
        par_nxt   = par;
        tx_nxt    = tx_o;
        busy_nxt  = busy_o;
        done_nxt  = 1'b0;
        clr       = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (send_i) begin
                    sr_nxt    = data_i;
                    idx_nxt   = '0;
                    par_nxt   = (PARITY_ODD != 0) ? ~^data_i : ^data_i;
                    clr       = 1'b1;
                    state_nxt = TX_START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_nxt = TX_DATA;
                    tx_nxt    = sr[0];
                end
            end
            TX_DATA: begin
                if (tick) begin
                    sr_nxt = sr >> 1;
                    if (idx == UART_BITIDX_W'(UART_DATA_W - 1)) begin
                        state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
                        tx_nxt    = PAR_EN ? par : 1'b1;
                    end else begin
                        idx_nxt = idx + UART_BITIDX_W'(1);
                        tx_nxt  = sr[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_nxt = TX_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            TX_STOP: begin
                done_nxt = pre_tick;
                if (tick) begin
                    state_nxt = TX_IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= TX_IDLE;
            sr     <= '0;
            idx    <= '0;
            par    <= 1'b0;
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            idx    <= idx_nxt;
            par    <= par_nxt;
            tx_o   <= tx_nxt;
            busy_o <= busy_nxt;
            done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_module_uart_tx.sv
// Directed bench for module_uart_tx: scoreboarded frames on a 4-clk/bit and a 2-clk/bit instance.
module tb_module_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send1 = 1'b0, send2 = 1'b0;
    logic [7:0] data1 = 8'h00, data2 = 8'h00;
    logic       tx1, busy1, done1, tx2, busy2, done2;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb1[$];
    logic [7:0] sb2[$];

    always #5 clk = ~clk;

    module_uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .send_i(send1), .data_i(data1),
        .tx_o(tx1), .busy_o(busy1), .done_o(done1)
    );

    module_uart_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .send_i(send2), .data_i(data2),
        .tx_o(tx2), .busy_o(busy2), .done_o(done2)
    );

    function automatic logic [2:0] obs(input int w);
        return (w != 0) ? {tx2, busy2, done2} : {tx1, busy1, done1};
    endfunction

    task automatic chk(input string tag, input logic [2:0] o, input logic [2:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed{tx,busy,done}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic send_byte(input int w, input logic [7:0] d);
        if (w != 0) begin
            data2 = d; send2 = 1'b1; sb2.push_back(d);
        end else begin
            data1 = d; send1 = 1'b1; sb1.push_back(d);
        end
        @(negedge clk);
        send1 = 1'b0;
        send2 = 1'b0;
    endtask

    task automatic idle_for(input int w, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, obs(w), 3'b100);
            @(negedge clk);
        end
    endtask

    // Entered on the first cycle after accept; ends on the first idle cycle after the frame.
    task automatic run_frame(input int w, input int inj_at, input int abort_at, input string tag);
        logic [7:0]  d;
        logic [10:0] fb;
        int          c, nb;
        logic        odd;
        d   = (w != 0) ? sb2.pop_front() : sb1.pop_front();
        c   = (w != 0) ? 2 : 4;
        odd = (w != 0);
        nb  = PAR_EN ? 11 : 10;
        fb  = '1;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[k+1] = d[k];
        if (PAR_EN) fb[9] = odd ? ~^d : ^d;
        for (int i = 0; i < nb * c; i++) begin
            chk(tag, obs(w), {fb[i / c], 1'b1, (i == nb * c - 1)});
            if (w != 0) data2 = ~data2;
            if (i == inj_at) begin
                send1 = 1'b1; data1 = 8'h81;
            end else begin
                send1 = 1'b0;
            end
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk({tag, "_rst"}, obs(w), 3'b100);
                @(negedge clk);
                idle_for(w, 45, {tag, "_after_rst"});
                return;
            end
            @(negedge clk);
        end
        chk({tag, "_end"}, obs(w), 3'b100);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_dut1", obs(0), 3'b100);
        chk("reset_dut2", obs(1), 3'b100);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, exact bit widths and done timing
        send_byte(0, 8'hA5);
        run_frame(0, -1, -1, "frame_a5");
        idle_for(0, 3, "idle_a5");

        // Back-to-back: second send in the first idle cycle after done
        send_byte(0, 8'h00);
        run_frame(0, -1, -1, "b2b_00");
        send_byte(0, 8'hFF);
        run_frame(0, -1, -1, "b2b_ff");
        idle_for(0, 3, "idle_b2b");

        // Send while busy is ignored and not queued
        send_byte(0, 8'h3C);
        run_frame(0, 9, -1, "busy_3c");
        idle_for(0, 50, "no_second_frame");

        // Reset mid-frame discards the frame, then a fresh frame works
        send_byte(0, 8'hC3);
        run_frame(0, -1, 16, "abort");
        send_byte(0, 8'h55);
        run_frame(0, -1, -1, "after_abort_55");

        // Two clocks per bit with data_i toggling after accept
        send_byte(1, 8'h6B);
        run_frame(1, -1, -1, "cpb2_6b");
        idle_for(1, 3, "idle_cpb2");

        if (PAR_EN) begin
            send_byte(1, 8'h01);
            run_frame(1, -1, -1, "par_odd_01");
            send_byte(1, 8'h03);
            run_frame(1, -1, -1, "par_odd_03");
        end

        checks++;
        assert (sb1.size() + sb2.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", sb1.size() + sb2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
